// File: rtl/clk50_rst_seq_pkg.sv
// Shared types and default constants for the clk50 reset sequencer.
// State encodings, retry-counter width and per-state reset pattern helper.
package clk50_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST    = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_DDR_RST    = 3'd2,
    ST_WAIT_CALIB = 3'd3,
    ST_CHAN_RST   = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } seq_state_e;

  localparam int unsigned RETRY_W                = 2;
  localparam int unsigned DEF_RST_CYCLES         = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 50000;
  localparam int unsigned DEF_CALIB_TIMEOUT      = 5000000;
  localparam int unsigned DEF_MAX_RETRIES        = 3;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 8;
  localparam int unsigned DEF_CNT_W              = 24;

  typedef struct packed {
    logic pll;
    logic ddr;
    logic chan;
  } rst_vec_t;

  // Active-high reset pattern held while in a given state.
  function automatic rst_vec_t resets_for(seq_state_e s);
    rst_vec_t r;
    r = '1;
    case (s)
      ST_PLL_RST:    r = '{pll: 1'b1, ddr: 1'b1, chan: 1'b1};
      ST_WAIT_LOCK:  r = '{pll: 1'b0, ddr: 1'b1, chan: 1'b1};
      ST_DDR_RST:    r = '{pll: 1'b0, ddr: 1'b1, chan: 1'b1};
      ST_WAIT_CALIB: r = '{pll: 1'b0, ddr: 1'b0, chan: 1'b1};
      ST_CHAN_RST:   r = '{pll: 1'b0, ddr: 1'b0, chan: 1'b1};
      ST_RUN:        r = '{pll: 1'b0, ddr: 1'b0, chan: 1'b0};
      ST_FAULT:      r = '{pll: 1'b1, ddr: 1'b1, chan: 1'b1};
      default:       r = '1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clk50_reset_sequencer_if.sv
// Handshake and status bundle between the reset sequencer and board logic.
// master = sequencer side, slave = board / status-register side.
interface clk50_reset_sequencer_if;
  import clk50_rst_seq_pkg::*;

  logic               pll_locked;
  logic               ddr_calib_done;
  logic               soft_rst_req;
  logic               rst_pll;
  logic               rst_ddr;
  logic               rst_chan;
  logic               seq_done;
  logic               seq_fault;
  logic [2:0]         seq_state;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    input  pll_locked,
    input  ddr_calib_done,
    input  soft_rst_req,
    output rst_pll,
    output rst_ddr,
    output rst_chan,
    output seq_done,
    output seq_fault,
    output seq_state,
    output retry_cnt
  );

  modport slave (
    output pll_locked,
    output ddr_calib_done,
    output soft_rst_req,
    input  rst_pll,
    input  rst_ddr,
    input  rst_chan,
    input  seq_done,
    input  seq_fault,
    input  seq_state,
    input  retry_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, async active-low reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk50_reset_sequencer.sv
// Steps clk50-domain logic out of reset: PLL, DDR controller, channel logic,
// with lock/calibration timeouts and bounded retry. Optional lock debounce:
// CLK50_RST_SEQ_LOCK_DEBOUNCE_EN.
module clk50_reset_sequencer
  import clk50_rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned DDR_RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned CHAN_RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned CALIB_TIMEOUT      = DEF_CALIB_TIMEOUT,
  parameter int unsigned MAX_RETRIES        = DEF_MAX_RETRIES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic                    clk50,
  input  logic                    rst_clk50_n,
  clk50_reset_sequencer_if.master seq_if
);

  localparam logic [CNT_W-1:0]   PLL_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DDR_LAST   = CNT_W'(DDR_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CHAN_LAST  = CNT_W'(CHAN_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CALIB_LAST = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  // Configuration sanity: every count must fit the shared timer, retries the counter.
  localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;
  localparam bit CFG_OK =
      (longint'(PLL_RST_CYCLES)     <= CNT_RANGE) && (PLL_RST_CYCLES  > 0) &&
      (longint'(DDR_RST_CYCLES)     <= CNT_RANGE) && (DDR_RST_CYCLES  > 0) &&
      (longint'(CHAN_RST_CYCLES)    <= CNT_RANGE) && (CHAN_RST_CYCLES > 0) &&
      (longint'(LOCK_TIMEOUT)       <= CNT_RANGE) && (LOCK_TIMEOUT    > 0) &&
      (longint'(CALIB_TIMEOUT)      <= CNT_RANGE) && (CALIB_TIMEOUT   > 0) &&
      (longint'(LOCK_STABLE_CYCLES) <= CNT_RANGE) && (LOCK_STABLE_CYCLES > 0) &&
      (MAX_RETRIES < (1 << RETRY_W));

  if (!CFG_OK) begin : g_cfg_check
    $error("clk50_reset_sequencer: parameter set does not fit CNT_W/RETRY_W");
  end

  logic lock_s;
  logic calib_s;
  logic lock_ok;

  sync_2ff u_sync_lock (
    .clk_i   (clk50),
    .rst_n_i (rst_clk50_n),
    .d_i     (seq_if.pll_locked),
    .q_o     (lock_s)
  );

  sync_2ff u_sync_calib (
    .clk_i   (clk50),
    .rst_n_i (rst_clk50_n),
    .d_i     (seq_if.ddr_calib_done),
    .q_o     (calib_s)
  );

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  rst_vec_t           rst_q,   rst_d;
  logic               done_q,  done_d;
  logic               fault_q, fault_d;
  logic               retry_req;

`ifdef CLK50_RST_SEQ_LOCK_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic [CNT_W-1:0] stable_q, stable_d;

  always_comb begin
    stable_d = '0;
    if (state_q == ST_WAIT_LOCK && lock_s) begin
      stable_d = stable_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk50 or negedge rst_clk50_n) begin
    if (!rst_clk50_n) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable_d;
    end
  end

  assign lock_ok = lock_s && (stable_q == STABLE_LAST);
`else
  assign lock_ok = lock_s;
`endif

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_req = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        if (timer_q == PLL_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_ok)                    state_d   = ST_DDR_RST;
        else if (timer_q == LOCK_LAST)  retry_req = 1'b1;
      end
      ST_DDR_RST: begin
        if (!lock_s)                    retry_req = 1'b1;
        else if (timer_q == DDR_LAST)   state_d   = ST_WAIT_CALIB;
      end
      ST_WAIT_CALIB: begin
        if (!lock_s)                    retry_req = 1'b1;
        else if (timer_q == CALIB_LAST) retry_req = 1'b1;
        else if (calib_s)               state_d   = ST_CHAN_RST;
      end
      ST_CHAN_RST: begin
        if (!lock_s)                    retry_req = 1'b1;
        else if (timer_q == CHAN_LAST)  state_d   = ST_RUN;
      end
      ST_RUN: begin
        // Lock loss after a completed sequence starts afresh rather than retrying.
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          retry_d = '0;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_PLL_RST;
    endcase

    if (retry_req) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = ST_PLL_RST;
      end else begin
        state_d = ST_FAULT;
      end
    end

    if (seq_if.soft_rst_req) begin
      state_d = ST_PLL_RST;
      retry_d = '0;
    end

    timer_d = (state_d != state_q || seq_if.soft_rst_req) ? '0 : timer_q + CNT_W'(1);
    rst_d   = resets_for(state_d);
    done_d  = (state_d == ST_RUN);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk50 or negedge rst_clk50_n) begin
    if (!rst_clk50_n) begin
      state_q <= ST_PLL_RST;
      timer_q <= '0;
      retry_q <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign seq_if.rst_pll   = rst_q.pll;
  assign seq_if.rst_ddr   = rst_q.ddr;
  assign seq_if.rst_chan  = rst_q.chan;
  assign seq_if.seq_done  = done_q;
  assign seq_if.seq_fault = fault_q;
  assign seq_if.seq_state = state_q;
  assign seq_if.retry_cnt = retry_q;

endmodule
